// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: fixed-latency mult/div, architectural HI/LO,
// and the combinational mfhi/mflo read path feeding E_MDUout.
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdu_out
);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } op_e;

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state;
  logic [3:0]  cnt;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic               div_signed;
  logic [31:0]        abs_a, abs_b, dvd, dvs, uq, ur;
  logic [31:0]        quo, rem;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // One unsigned divider serves both div and divu; signed results are rebuilt
  // from magnitudes, which also makes 0x80000000 / -1 come out as 0x80000000.
  assign div_signed = (mdu_op == OP_DIV);
  assign abs_a      = a[31] ? (~a + 32'd1) : a;
  assign abs_b      = b[31] ? (~b + 32'd1) : b;
  assign dvd        = div_signed ? abs_a : a;
  assign dvs        = (b == '0) ? 32'd1 : (div_signed ? abs_b : b);
  assign uq         = dvd / dvs;
  assign ur         = dvd % dvs;
  assign quo        = (div_signed && (a[31] ^ b[31])) ? (~uq + 32'd1) : uq;
  assign rem        = (div_signed && a[31]) ? (~ur + 32'd1) : ur;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (mdu_op)
              OP_MULT: begin
                {pend_hi, pend_lo} <= prod_s;
                cnt   <= 4'(MULT_CYCLES);
                busy  <= 1'b1;
                state <= RUN;
              end
              OP_MULTU: begin
                {pend_hi, pend_lo} <= prod_u;
                cnt   <= 4'(MULT_CYCLES);
                busy  <= 1'b1;
                state <= RUN;
              end
              OP_DIV, OP_DIVU: begin
                // HI/LO cannot change during RUN, so a divide by zero simply
                // re-commits the current values.
                if (b == '0) begin
                  pend_hi <= hi;
                  pend_lo <= lo;
                end else begin
                  pend_hi <= rem;
                  pend_lo <= quo;
                end
                cnt   <= 4'(DIV_CYCLES);
                busy  <= 1'b1;
                state <= RUN;
              end
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              default: ;
            endcase
          end
        end
        RUN: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            hi    <= pend_hi;
            lo    <= pend_lo;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mdu_out = '0;
    if (start && mdu_op == OP_MFHI) mdu_out = hi;
    else if (start && mdu_op == OP_MFLO) mdu_out = lo;
  end

endmodule
